// File: rtl/vector_load.sv
// vector_load: LOAD engine that fetches bytes from DRAM one request at a time and packs them into tiles.
// Build option VECTOR_LOAD_ZERO_PAD_EN clears all lanes on start and after every tile write.
module vector_load #(
  parameter int DATA_WIDTH = 8,
  parameter int TILE_WIDTH = 256,
  parameter int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH,
  parameter int ADDR_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4:0]            dst_buffer_id,
  input  logic [9:0]            length,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  buf_write_en,
  output logic [4:0]            buf_write_id,
  output logic [5:0]            buf_write_idx,
  output logic [DATA_WIDTH-1:0] buf_write_tile [0:TILE_ELEMS-1]
);

  localparam int LANE_W = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_r;
  logic [9:0]              length_r;
  logic [9:0]              byte_cnt_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [5:0]              tile_idx_r;

  logic [9:0]              byte_cnt_inc_s;
  logic [LANE_W-1:0]       lane_s;
  logic                    last_lane_s;
  logic                    last_byte_s;

  // Lane selection and tile/load termination for the byte being received.
  always_comb begin
    byte_cnt_inc_s = byte_cnt_r + 10'd1;
    lane_s         = LANE_W'(byte_cnt_r % 10'(TILE_ELEMS));
    last_lane_s    = (lane_s == LANE_W'(TILE_ELEMS - 1));
    last_byte_s    = (byte_cnt_inc_s == length_r);
  end

  // Load sequencer; every output, including the lane registers, is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      length_r      <= '0;
      byte_cnt_r    <= '0;
      addr_r        <= '0;
      tile_idx_r    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      buf_write_en  <= 1'b0;
      buf_write_id  <= '0;
      buf_write_idx <= '0;
      for (int i = 0; i < TILE_ELEMS; i++) buf_write_tile[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // busy stays high through the done pulse and drops on the following edge
          busy <= 1'b0;
          if (start) begin
            busy         <= 1'b1;
            buf_write_id <= dst_buffer_id;
            length_r     <= length;
            addr_r       <= addr;
            byte_cnt_r   <= '0;
            tile_idx_r   <= '0;
`ifdef VECTOR_LOAD_ZERO_PAD_EN
            for (int i = 0; i < TILE_ELEMS; i++) buf_write_tile[i] <= '0;
`endif
            if (length == 10'd0) begin
              state_r <= S_DONE;
            end else begin
              state_r  <= S_REQ;
              mem_req  <= 1'b1;
              mem_addr <= addr;
            end
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state_r <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            buf_write_tile[lane_s] <= mem_rdata;
            byte_cnt_r             <= byte_cnt_inc_s;
            if (last_lane_s || last_byte_s) begin
              state_r       <= S_WRITE;
              buf_write_en  <= 1'b1;
              buf_write_idx <= tile_idx_r;
            end else begin
              state_r  <= S_REQ;
              mem_req  <= 1'b1;
              mem_addr <= addr_r + ADDR_WIDTH'(byte_cnt_inc_s);
            end
          end
        end
        S_WRITE: begin
          buf_write_en <= 1'b0;
          tile_idx_r   <= tile_idx_r + 6'd1;
`ifdef VECTOR_LOAD_ZERO_PAD_EN
          for (int i = 0; i < TILE_ELEMS; i++) buf_write_tile[i] <= '0;
`endif
          if (byte_cnt_r == length_r) begin
            state_r <= S_DONE;
          end else begin
            state_r  <= S_REQ;
            mem_req  <= 1'b1;
            mem_addr <= addr_r + ADDR_WIDTH'(byte_cnt_r);
          end
        end
        S_DONE: begin
          done    <= 1'b1;
          state_r <= S_IDLE;
        end
        default: begin
          state_r      <= S_IDLE;
          busy         <= 1'b0;
          mem_req      <= 1'b0;
          buf_write_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_load.sv
// Randomized self-checking bench for vector_load against a byte-level tile-packing model.
// The model follows VECTOR_LOAD_ZERO_PAD_EN the same way the design build does.
module tb_vector_load;

  localparam int TE = 32;
`ifdef VECTOR_LOAD_ZERO_PAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  dst_buffer_id = 5'd0;
  logic [9:0]  length = 10'd0;
  logic [23:0] addr = 24'd0;
  logic        busy, done, mem_req;
  logic [23:0] mem_addr;
  logic        mem_ready = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [7:0]  mem_rdata = 8'd0;
  logic        buf_write_en;
  logic [4:0]  buf_write_id;
  logic [5:0]  buf_write_idx;
  logic [7:0]  buf_write_tile [0:TE-1];

  vector_load dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dst_buffer_id(dst_buffer_id),
    .length(length), .addr(addr), .busy(busy), .done(done), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .buf_write_en(buf_write_en), .buf_write_id(buf_write_id),
    .buf_write_idx(buf_write_idx), .buf_write_tile(buf_write_tile)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  seed = 8'd0;
  bit          rand_mem = 1'b0;
  bit          noise_en = 1'b0;
  int          stall_left = 0;
  logic [23:0] stall_addr = 24'd0;
  int          done_cnt = 0;
  logic [23:0] addr_q [$];
  logic [5:0]  wr_idx_q [$];
  logic [4:0]  wr_id_q [$];
  logic [255:0] wr_tile_q [$];
  logic [7:0]  stale [0:TE-1];

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ seed;
  endfunction

  function automatic logic [255:0] tile_bits();
    logic [255:0] t;
    for (int i = 0; i < TE; i++) t[i*8 +: 8] = buf_write_tile[i];
    return t;
  endfunction

  // DRAM responder: one outstanding read, optional random ready/latency and stray rvalid
  initial begin : responder
    bit          acc;
    logic [23:0] acc_addr;
    bit          pend;
    logic [23:0] pend_addr;
    int          rv_wait;
    pend = 1'b0;
    pend_addr = 24'd0;
    rv_wait = 0;
    forever begin
      @(posedge clk);
      acc = mem_req && mem_ready && rst_n;
      acc_addr = mem_addr;
      @(negedge clk);
      if (!rst_n) pend = 1'b0;
      if (acc) begin
        pend = 1'b1;
        pend_addr = acc_addr;
        rv_wait = rand_mem ? int'($urandom_range(0, 2)) : 0;
        addr_q.push_back(acc_addr);
      end
      mem_rvalid = 1'b0;
      mem_rdata = 8'($urandom);
      if (pend) begin
        if (rv_wait == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = mem_byte(pend_addr);
          pend = 1'b0;
        end else begin
          rv_wait--;
        end
      end else if (noise_en && $urandom_range(0, 3) == 0) begin
        mem_rvalid = 1'b1;
      end
      if (stall_left > 0 && mem_req) begin
        check_eq("stall_addr", 256'(mem_addr), 256'(stall_addr));
        mem_ready = 1'b0;
        stall_left--;
      end else begin
        mem_ready = rand_mem ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // Output monitor: collects tile writes and done pulses
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (buf_write_en) begin
        wr_idx_q.push_back(buf_write_idx);
        wr_id_q.push_back(buf_write_id);
        wr_tile_q.push_back(tile_bits());
      end
      if (done) done_cnt++;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 256'(busy), 256'(0));
    check_eq({tag, "_done"}, 256'(done), 256'(0));
    check_eq({tag, "_req"}, 256'(mem_req), 256'(0));
    check_eq({tag, "_addr"}, 256'(mem_addr), 256'(0));
    check_eq({tag, "_wen"}, 256'(buf_write_en), 256'(0));
    check_eq({tag, "_wid"}, 256'(buf_write_id), 256'(0));
    check_eq({tag, "_widx"}, 256'(buf_write_idx), 256'(0));
    check_eq({tag, "_tile"}, tile_bits(), 256'(0));
  endtask

  task automatic run_load(input logic [23:0] a, input int len, input logic [4:0] id, input bit zero_wait);
    int start_cyc, got_cyc, budget, ntiles;
    bit got;
    logic [7:0] lanes [0:TE-1];
    logic [255:0] et;
    addr_q.delete();
    wr_idx_q.delete();
    wr_id_q.delete();
    wr_tile_q.delete();
    done_cnt = 0;
    ntiles = (len + TE - 1) / TE;
    @(negedge clk);
    dst_buffer_id = id;
    length = 10'(len);
    addr = a;
    start = 1'b1;
    start_cyc = cyc;
    budget = 12 * len + 100;
    got = 1'b0;
    got_cyc = 0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if (c == 1 && len > 0) begin
        start = 1'b1;
        dst_buffer_id = ~id;
        length = 10'd5;
        addr = ~a;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        got_cyc = cyc;
      end
    end
    start = 1'b0;
    check_eq("done_seen", 256'(got), 256'(1));
    if (zero_wait) check_eq("latency", 256'(got_cyc - start_cyc), 256'(2 * len + ntiles + 2));
    @(negedge clk);
    check_eq("busy_after_done", 256'(busy), 256'(0));
    check_eq("done_width", 256'(done), 256'(0));
    check_eq("done_count", 256'(done_cnt), 256'(1));
    check_eq("n_reqs", 256'(addr_q.size()), 256'(len));
    check_eq("n_writes", 256'(wr_idx_q.size()), 256'(ntiles));
    for (int k = 0; k < len && k < addr_q.size(); k++)
      check_eq("req_addr", 256'(addr_q[k]), 256'(24'(a + 24'(k))));
    for (int t = 0; t < ntiles; t++) begin
      for (int i = 0; i < TE; i++) lanes[i] = ZP ? 8'd0 : stale[i];
      for (int k = t * TE; k < len && k < (t + 1) * TE; k++) lanes[k % TE] = mem_byte(24'(a + 24'(k)));
      for (int i = 0; i < TE; i++) begin
        stale[i] = lanes[i];
        et[i*8 +: 8] = lanes[i];
      end
      if (t < wr_idx_q.size()) begin
        check_eq("wr_idx", 256'(wr_idx_q[t]), 256'(t));
        check_eq("wr_id", 256'(wr_id_q[t]), 256'(id));
        check_eq("wr_tile", wr_tile_q[t], et);
      end
    end
  endtask

  task automatic mid_reset();
    bit reached;
    reached = 1'b0;
    addr_q.delete();
    wr_idx_q.delete();
    wr_id_q.delete();
    wr_tile_q.delete();
    done_cnt = 0;
    seed = 8'h5A;
    @(negedge clk);
    dst_buffer_id = 5'd2;
    length = 10'd32;
    addr = 24'h000400;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && !reached; c++) begin
      @(negedge clk);
      if (addr_q.size() >= 10) reached = 1'b1;
    end
    check_eq("mid_reached", 256'(reached), 256'(1));
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    repeat (4) @(negedge clk);
    check_eq("rst_no_done", 256'(done_cnt), 256'(0));
    check_eq("rst_no_write", 256'(wr_idx_q.size()), 256'(0));
    rst_n = 1'b1;
    for (int i = 0; i < TE; i++) stale[i] = 8'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_idle_busy", 256'(busy), 256'(0));
  endtask

  initial begin
    for (int i = 0; i < TE; i++) stale[i] = 8'd0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_busy", 256'(busy), 256'(0));

    seed = 8'd0;
    run_load(24'h000100, 32, 5'd3, 1'b1);
    run_load(24'h000000, 40, 5'd7, 1'b1);
    run_load(24'h000ABC, 0, 5'd1, 1'b1);
    run_load(24'hFFFFFE, 4, 5'd9, 1'b1);

    stall_left = 5;
    stall_addr = 24'h001230;
    run_load(24'h001230, 10, 5'd4, 1'b0);
    check_eq("stall_consumed", 256'(stall_left), 256'(0));

    mid_reset();
    run_load(24'h000200, 32, 5'd12, 1'b1);

    rand_mem = 1'b1;
    noise_en = 1'b1;
    for (int r = 0; r < 10; r++) begin
      seed = 8'($urandom);
      run_load(24'($urandom), (r == 0) ? 1023 : int'($urandom_range(1, 100)), 5'($urandom), 1'b0);
    end
    rand_mem = 1'b0;
    noise_en = 1'b0;
    seed = 8'($urandom);
    run_load(24'($urandom), int'($urandom_range(1, 70)), 5'($urandom), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
